// File: rtl/anc_sample_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// anc_sample_sequencer_pkg
// Shared definitions for the ANC sample sequencer.
// Contents:
//   AXIS_W         width of an AXIS audio word
//   DATA_W_DEF     default audio sample width
//   TIMEOUT_DEF    default compute deadline in clock cycles
//   CNT_W_DEF      default width of the saturating error counters
//   state_e        sequencer FSM states
//   is_rx_state()  1 in the states that accept rx words
// -----------------------------------------------------------------------------
package anc_sample_sequencer_pkg;

    localparam int AXIS_W      = 32;
    localparam int DATA_W_DEF  = 24;
    localparam int TIMEOUT_DEF = 400;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_RX_L  = 3'd0,  // waiting for the left (reference) word
        ST_RX_R  = 3'd1,  // waiting for the right (error) word
        ST_START = 3'd2,  // one-cycle core launch
        ST_WAIT  = 3'd3,  // waiting for core_done or the deadline
        ST_TX_L  = 3'd4,  // presenting the left tx word
        ST_TX_R  = 3'd5   // presenting the right tx word
    } state_e;

    function automatic logic is_rx_state(input state_e s);
        return (s == ST_RX_L) || (s == ST_RX_R);
    endfunction

endpackage

// File: rtl/anc_deadline_timer.sv
// -----------------------------------------------------------------------------
// anc_deadline_timer
// Cycle counter for the filter-core compute deadline. It counts from 0 while
// enabled and flags expiry on the cycle the count reaches TIMEOUT-1, so an
// enabled window lasts exactly TIMEOUT cycles before expiry is acted upon.
// Ports:
//   clk_i      clock
//   rst_i      synchronous reset, active-high
//   clear_i    force the count back to 0 (has priority over enable_i)
//   enable_i   count this cycle
//   expired_o  count has reached TIMEOUT-1 while enabled
// -----------------------------------------------------------------------------
module anc_deadline_timer #(
    parameter int TIMEOUT = 400
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = enable_i && (cnt_q == LAST_CNT);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/anc_sample_sequencer.sv
// -----------------------------------------------------------------------------
// anc_sample_sequencer
// Per-frame scheduler between the I2S AXIS controller and the ANC filter core.
// Collects one {left=reference, right=error} rx packet, launches the core,
// enforces a compute deadline and returns the anti-noise sample as a two-word
// tx packet (same value on L and R). A missed deadline re-sends the last good
// sample so the codec is never starved.
// Ports:
//   axis_clk, axis_reset         clock, synchronous active-high reset
//   rx_axis_s_*                  codec rx stream (last=1 marks the right word)
//   tx_axis_m_*                  codec tx stream (last=1 marks the right word)
//   core_start/core_ref/core_err launch pulse and latched operands for the core
//   core_done/core_out           result pulse and anti-noise sample
//   bypass                       transmit core_ref directly (sampled in START)
//   overrun_count                saturating count of deadline misses
//   desync_count                 saturating count of rx framing errors
// -----------------------------------------------------------------------------
module anc_sample_sequencer
    import anc_sample_sequencer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              axis_clk,
    input  logic              axis_reset,
    input  logic [AXIS_W-1:0] rx_axis_s_data,
    input  logic              rx_axis_s_valid,
    output logic              rx_axis_s_ready,
    input  logic              rx_axis_s_last,
    output logic [AXIS_W-1:0] tx_axis_m_data,
    output logic              tx_axis_m_valid,
    input  logic              tx_axis_m_ready,
    output logic              tx_axis_m_last,
    output logic              core_start,
    output logic [DATA_W-1:0] core_ref,
    output logic [DATA_W-1:0] core_err,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_out,
    input  logic              bypass,
    output logic [CNT_W-1:0]  overrun_count,
    output logic [CNT_W-1:0]  desync_count
);

    state_e              state_q;
    logic                rx_ready_q;
    logic [AXIS_W-1:0]   tx_data_q;
    logic                tx_valid_q;
    logic                tx_last_q;
    logic                core_start_q;
    logic [DATA_W-1:0]   core_ref_q;
    logic [DATA_W-1:0]   core_err_q;
    logic [DATA_W-1:0]   held_q;       // last good anti-noise sample
    logic [CNT_W-1:0]    overrun_q;
    logic [CNT_W-1:0]    desync_q;

    logic [CNT_W-1:0]    overrun_d;
    logic [CNT_W-1:0]    desync_d;
    logic                rx_accept;
    logic                timer_expired;
    logic [DATA_W-1:0]   rx_sample;

    // Upper bits of an rx word are padding and carry no information.
    logic                unused_rx_pad;
    assign unused_rx_pad = ^rx_axis_s_data[AXIS_W-1:DATA_W];

    assign rx_sample = rx_axis_s_data[DATA_W-1:0];
    assign rx_accept = rx_axis_s_valid && rx_ready_q;

    // Saturating increments; the FSM decides when they are committed.
    assign overrun_d = (overrun_q == '1) ? overrun_q : overrun_q + 1'b1;
    assign desync_d  = (desync_q  == '1) ? desync_q  : desync_q  + 1'b1;

    anc_deadline_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (axis_clk),
        .rst_i     (axis_reset),
        .clear_i   (state_q != ST_WAIT),
        .enable_i  (state_q == ST_WAIT),
        .expired_o (timer_expired)
    );

    function automatic logic [AXIS_W-1:0] pack_word(input logic [DATA_W-1:0] s);
        return {{(AXIS_W - DATA_W){1'b0}}, s};
    endfunction

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            state_q      <= ST_RX_L;
            rx_ready_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_ref_q   <= '0;
            core_err_q   <= '0;
            held_q       <= '0;
            overrun_q    <= '0;
            desync_q     <= '0;
        end else begin
            case (state_q)
                ST_RX_L: begin
                    // Ready comes up one cycle after reset, then stays up in rx states.
                    rx_ready_q <= 1'b1;
                    if (rx_accept) begin
                        if (rx_axis_s_last) begin
                            desync_q <= desync_d;            // stray right word: drop
                        end else begin
                            core_ref_q <= rx_sample;
                            state_q    <= ST_RX_R;
                        end
                    end
                end

                ST_RX_R: begin
                    rx_ready_q <= 1'b1;
                    if (rx_accept) begin
                        if (rx_axis_s_last) begin
                            core_err_q   <= rx_sample;
                            core_start_q <= 1'b1;
                            rx_ready_q   <= 1'b0;
                            state_q      <= ST_START;
                        end else begin
                            core_ref_q <= rx_sample;         // newer left word wins
                            desync_q   <= desync_d;
                        end
                    end
                end

                ST_START: begin
                    core_start_q <= 1'b0;
                    if (bypass) begin
                        held_q     <= core_ref_q;
                        tx_data_q  <= pack_word(core_ref_q);
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                        state_q    <= ST_TX_L;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // A result on the deadline cycle still counts as on time.
                    if (core_done) begin
                        held_q     <= core_out;
                        tx_data_q  <= pack_word(core_out);
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                        state_q    <= ST_TX_L;
                    end else if (timer_expired) begin
                        overrun_q  <= overrun_d;
                        tx_data_q  <= pack_word(held_q);
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                        state_q    <= ST_TX_L;
                    end
                end

                ST_TX_L: begin
                    if (tx_axis_m_ready) begin
                        tx_last_q <= 1'b1;
                        state_q   <= ST_TX_R;
                    end
                end

                ST_TX_R: begin
                    if (tx_axis_m_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        rx_ready_q <= 1'b1;
                        state_q    <= ST_RX_L;
                    end
                end

                default: begin
                    state_q <= ST_RX_L;
                end
            endcase
        end
    end

    assign rx_axis_s_ready = rx_ready_q;
    assign tx_axis_m_data  = tx_data_q;
    assign tx_axis_m_valid = tx_valid_q;
    assign tx_axis_m_last  = tx_last_q;
    assign core_start      = core_start_q;
    assign core_ref        = core_ref_q;
    assign core_err        = core_err_q;
    assign overrun_count   = overrun_q;
    assign desync_count    = desync_q;

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_anc_sample_sequencer
// Directed scenarios for the ANC sample sequencer. Inputs are driven on the
// falling edge or 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_anc_sample_sequencer;

    localparam int DATA_W  = 24;
    localparam int TIMEOUT = 400;
    localparam int CNT_W   = 16;

    logic              axis_clk = 1'b0;
    logic              axis_reset = 1'b1;
    logic [31:0]       rx_axis_s_data = '0;
    logic              rx_axis_s_valid = 1'b0;
    logic              rx_axis_s_ready;
    logic              rx_axis_s_last = 1'b0;
    logic [31:0]       tx_axis_m_data;
    logic              tx_axis_m_valid;
    logic              tx_axis_m_ready = 1'b0;
    logic              tx_axis_m_last;
    logic              core_start;
    logic [DATA_W-1:0] core_ref;
    logic [DATA_W-1:0] core_err;
    logic              core_done = 1'b0;
    logic [DATA_W-1:0] core_out = '0;
    logic              bypass = 1'b0;
    logic [CNT_W-1:0]  overrun_count;
    logic [CNT_W-1:0]  desync_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 axis_clk = ~axis_clk;

    anc_sample_sequencer #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .axis_clk        (axis_clk),
        .axis_reset      (axis_reset),
        .rx_axis_s_data  (rx_axis_s_data),
        .rx_axis_s_valid (rx_axis_s_valid),
        .rx_axis_s_ready (rx_axis_s_ready),
        .rx_axis_s_last  (rx_axis_s_last),
        .tx_axis_m_data  (tx_axis_m_data),
        .tx_axis_m_valid (tx_axis_m_valid),
        .tx_axis_m_ready (tx_axis_m_ready),
        .tx_axis_m_last  (tx_axis_m_last),
        .core_start      (core_start),
        .core_ref        (core_ref),
        .core_err        (core_err),
        .core_done       (core_done),
        .core_out        (core_out),
        .bypass          (bypass),
        .overrun_count   (overrun_count),
        .desync_count    (desync_count)
    );

    // ---------------------------------------------------------------- helpers
    // Offer one rx word and hold it until accepted; returns 1 ns after the edge.
    task automatic send_rx(input logic [23:0] s, input logic last);
        bit ok;
        ok = 1'b0;
        @(negedge axis_clk);
        rx_axis_s_data  = {8'h00, s};
        rx_axis_s_last  = last;
        rx_axis_s_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (rx_axis_s_ready) ok = 1'b1;
            else @(negedge axis_clk);
        end
        if (ok) begin
            @(posedge axis_clk);
            #1;
        end
        rx_axis_s_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rx_handshake: ready=%0b after 100 cycles, required 1", rx_axis_s_ready);
        end
    endtask

    // One-cycle core_done pulse; returns 1 ns after the edge that sampled it.
    task automatic core_pulse(input logic [23:0] s);
        @(negedge axis_clk);
        core_done = 1'b1;
        core_out  = s;
        @(posedge axis_clk);
        #1;
        core_done = 1'b0;
    endtask

    // Wait for tx valid, then accept both words and report what was seen.
    task automatic drain_tx(output logic [31:0] d0, output logic l0,
                            output logic [31:0] d1, output logic l1);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge axis_clk);
            if (tx_axis_m_valid) seen = 1'b1;
        end
        d0 = tx_axis_m_data;
        l0 = tx_axis_m_last;
        tx_axis_m_ready = 1'b1;
        @(posedge axis_clk);
        #1;
        d1 = tx_axis_m_data;
        l1 = tx_axis_m_last;
        @(posedge axis_clk);
        #1;
        tx_axis_m_ready = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL tx_wait: valid=%0b after 1000 cycles, required 1", tx_axis_m_valid);
        end
    endtask

    // --------------------------------------------------------------- scenarios
    task automatic test_reset();
        logic [115:0] outs;
        axis_reset = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;
        outs = {rx_axis_s_ready, tx_axis_m_valid, tx_axis_m_last, tx_axis_m_data,
                core_start, core_ref, core_err, overrun_count, desync_count};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        @(negedge axis_clk);
        axis_reset = 1'b0;
        @(posedge axis_clk);
        #1;
        n_cmp++;
        if (rx_axis_s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rx_ready: got %0b, required 1", rx_axis_s_ready);
        end
    endtask

    task automatic test_normal_frame();
        int pulses;
        bit early;
        logic [31:0] d0, d1;
        logic l0, l1;
        send_rx(24'h000123, 1'b0);
        send_rx(24'h000456, 1'b1);
        pulses = core_start ? 1 : 0;
        n_cmp++;
        if (core_ref !== 24'h000123 || core_err !== 24'h000456) begin
            n_bad++;
            $display("FAIL normal_operands: ref=%h err=%h, required 000123/000456", core_ref, core_err);
        end
        early = 1'b0;
        repeat (49) begin
            @(posedge axis_clk);
            #1;
            if (core_start) pulses++;
            if (tx_axis_m_valid) early = 1'b1;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL normal_start_pulses: got %0d, required 1", pulses);
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL normal_early_valid: got %0b, required 0", early);
        end
        core_pulse(24'h0ABCDE);
        n_cmp++;
        if (tx_axis_m_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL normal_valid_latency: got %0b, required 1", tx_axis_m_valid);
        end
        drain_tx(d0, l0, d1, l1);
        n_cmp++;
        if ({d0, l0, d1, l1} !== {32'h000ABCDE, 1'b0, 32'h000ABCDE, 1'b1}) begin
            n_bad++;
            $display("FAIL normal_tx: got %h/%0b %h/%0b, required 000abcde/0 000abcde/1", d0, l0, d1, l1);
        end
        n_cmp++;
        if (tx_axis_m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL normal_tx_end: valid=%0b, required 0", tx_axis_m_valid);
        end
    endtask

    task automatic test_deadline_miss();
        logic [31:0] d0, d1;
        logic l0, l1;
        send_rx(24'h000111, 1'b0);
        send_rx(24'h000222, 1'b1);
        // START cycle, then TIMEOUT cycles of WAIT; valid rises the cycle after.
        repeat (TIMEOUT) @(posedge axis_clk);
        #1;
        n_cmp++;
        if (tx_axis_m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL deadline_before: valid=%0b, required 0", tx_axis_m_valid);
        end
        @(posedge axis_clk);
        #1;
        n_cmp++;
        if (tx_axis_m_valid !== 1'b1 || tx_axis_m_data !== 32'h000ABCDE) begin
            n_bad++;
            $display("FAIL deadline_tx: valid=%0b data=%h, required 1/000abcde", tx_axis_m_valid, tx_axis_m_data);
        end
        n_cmp++;
        if (overrun_count !== 16'd1) begin
            n_bad++;
            $display("FAIL deadline_overrun: got %0d, required 1", overrun_count);
        end
        // Late result while the substitute is being presented.
        core_pulse(24'h055555);
        n_cmp++;
        if (tx_axis_m_data !== 32'h000ABCDE || tx_axis_m_last !== 1'b0) begin
            n_bad++;
            $display("FAIL deadline_late_done: data=%h last=%0b, required 000abcde/0", tx_axis_m_data, tx_axis_m_last);
        end
        drain_tx(d0, l0, d1, l1);
        n_cmp++;
        if ({d0, l0, d1, l1} !== {32'h000ABCDE, 1'b0, 32'h000ABCDE, 1'b1}) begin
            n_bad++;
            $display("FAIL deadline_drain: got %h/%0b %h/%0b, required 000abcde/0 000abcde/1", d0, l0, d1, l1);
        end
        n_cmp++;
        if (overrun_count !== 16'd1) begin
            n_bad++;
            $display("FAIL deadline_overrun_after: got %0d, required 1", overrun_count);
        end
    endtask

    task automatic test_framing();
        logic [31:0] d0, d1;
        logic l0, l1;
        send_rx(24'h000999, 1'b1);
        n_cmp++;
        if (desync_count !== 16'd1 || core_ref !== 24'h000111) begin
            n_bad++;
            $display("FAIL framing_stray_right: desync=%0d ref=%h, required 1/000111", desync_count, core_ref);
        end
        send_rx(24'h000AAA, 1'b0);
        send_rx(24'h000BBB, 1'b0);
        n_cmp++;
        if (desync_count !== 16'd2 || core_ref !== 24'h000BBB) begin
            n_bad++;
            $display("FAIL framing_resync: desync=%0d ref=%h, required 2/000bbb", desync_count, core_ref);
        end
        send_rx(24'h000CCC, 1'b1);
        n_cmp++;
        if (core_start !== 1'b1 || core_err !== 24'h000CCC || desync_count !== 16'd2) begin
            n_bad++;
            $display("FAIL framing_start: start=%0b err=%h desync=%0d, required 1/000ccc/2", core_start, core_err, desync_count);
        end
        repeat (3) @(posedge axis_clk);
        core_pulse(24'h012345);
        drain_tx(d0, l0, d1, l1);
        n_cmp++;
        if ({d0, l0, d1, l1} !== {32'h00012345, 1'b0, 32'h00012345, 1'b1}) begin
            n_bad++;
            $display("FAIL framing_tx: got %h/%0b %h/%0b, required 00012345/0 00012345/1", d0, l0, d1, l1);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0, d1;
        logic l0, l1;
        bit unstable;
        send_rx(24'h000100, 1'b0);
        send_rx(24'h000200, 1'b1);
        repeat (5) @(posedge axis_clk);
        core_pulse(24'h054321);
        // Offer an rx word during backpressure; it must not be taken.
        rx_axis_s_data  = 32'h00000777;
        rx_axis_s_last  = 1'b1;
        rx_axis_s_valid = 1'b1;
        unstable = 1'b0;
        repeat (20) begin
            @(posedge axis_clk);
            #1;
            if (tx_axis_m_data !== 32'h00054321 || tx_axis_m_last !== 1'b0 ||
                tx_axis_m_valid !== 1'b1 || rx_axis_s_ready !== 1'b0) unstable = 1'b1;
        end
        rx_axis_s_valid = 1'b0;
        n_cmp++;
        if (unstable !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_stable: unstable=%0b, required 0", unstable);
        end
        drain_tx(d0, l0, d1, l1);
        n_cmp++;
        if ({d0, l0, d1, l1} !== {32'h00054321, 1'b0, 32'h00054321, 1'b1}) begin
            n_bad++;
            $display("FAIL backpressure_tx: got %h/%0b %h/%0b, required 00054321/0 00054321/1", d0, l0, d1, l1);
        end
        n_cmp++;
        if (desync_count !== 16'd2) begin
            n_bad++;
            $display("FAIL backpressure_desync: got %0d, required 2", desync_count);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] d0, d1;
        logic l0, l1;
        bypass = 1'b1;
        send_rx(24'h7FFFFF, 1'b0);
        send_rx(24'h000001, 1'b1);
        n_cmp++;
        if (core_start !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_start: got %0b, required 1", core_start);
        end
        @(posedge axis_clk);
        #1;
        n_cmp++;
        if (tx_axis_m_valid !== 1'b1 || tx_axis_m_data !== 32'h007FFFFF) begin
            n_bad++;
            $display("FAIL bypass_latency: valid=%0b data=%h, required 1/007fffff", tx_axis_m_valid, tx_axis_m_data);
        end
        drain_tx(d0, l0, d1, l1);
        bypass = 1'b0;
        n_cmp++;
        if ({d0, l0, d1, l1} !== {32'h007FFFFF, 1'b0, 32'h007FFFFF, 1'b1}) begin
            n_bad++;
            $display("FAIL bypass_tx: got %h/%0b %h/%0b, required 007fffff/0 007fffff/1", d0, l0, d1, l1);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [115:0] outs;
        logic [31:0] d0, d1;
        logic l0, l1;
        bit late_valid;
        send_rx(24'h000AAA, 1'b0);
        send_rx(24'h000BBB, 1'b1);
        repeat (10) @(posedge axis_clk);
        @(negedge axis_clk);
        axis_reset = 1'b1;
        @(posedge axis_clk);
        #1;
        outs = {rx_axis_s_ready, tx_axis_m_valid, tx_axis_m_last, tx_axis_m_data,
                core_start, core_ref, core_err, overrun_count, desync_count};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL wait_reset_outputs: got %h, required 0", outs);
        end
        @(negedge axis_clk);
        axis_reset = 1'b0;
        core_pulse(24'h0FFFFF);
        late_valid = 1'b0;
        repeat (5) begin
            @(posedge axis_clk);
            #1;
            if (tx_axis_m_valid) late_valid = 1'b1;
        end
        n_cmp++;
        if (late_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_reset_late_done: valid seen=%0b, required 0", late_valid);
        end
        send_rx(24'h000321, 1'b0);
        send_rx(24'h000654, 1'b1);
        n_cmp++;
        if (core_ref !== 24'h000321 || core_err !== 24'h000654) begin
            n_bad++;
            $display("FAIL wait_reset_operands: ref=%h err=%h, required 000321/000654", core_ref, core_err);
        end
        repeat (2) @(posedge axis_clk);
        core_pulse(24'h011111);
        drain_tx(d0, l0, d1, l1);
        n_cmp++;
        if ({d0, l0, d1, l1} !== {32'h00011111, 1'b0, 32'h00011111, 1'b1}) begin
            n_bad++;
            $display("FAIL wait_reset_tx: got %h/%0b %h/%0b, required 00011111/0 00011111/1", d0, l0, d1, l1);
        end
        n_cmp++;
        if (overrun_count !== 16'd0 || desync_count !== 16'd0) begin
            n_bad++;
            $display("FAIL wait_reset_counters: overrun=%0d desync=%0d, required 0/0", overrun_count, desync_count);
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_deadline_miss();
        test_framing();
        test_backpressure();
        test_bypass();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
